// File: rtl/updown_ctrl_pkg.sv
// updown_ctrl_pkg: shared state encoding, direction codes and default widths for the counter controller
package updown_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int WIDTH_DEF = 4;
    localparam int STEP_W_DEF = 4;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; a contest goes to the requester not granted last
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_q;
    assign gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= 1'b1;
        else if (advance) last_q <= gnt[1];
    end
endmodule

// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl: arbitrates two step requests and drives an external up/down counter's controls
module updown_count_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_clear,
    input  logic [1:0]        req_dir,
    input  logic [STEP_W-1:0] req_steps0,
    input  logic [STEP_W-1:0] req_steps1,
    output logic [1:0]        req_ready,
    output logic [1:0]        done,
    output logic [WIDTH-1:0]  result,
    output logic              busy,
    output logic              cnt_en,
    output logic              cnt_select,
    output logic              cnt_clear,
    input  logic [WIDTH-1:0]  cnt_q
);
    state_e state_q;
    logic id_q, dir_q, accept, gid;
    logic [STEP_W-1:0] steps_q, sel_steps;
    logic [WIDTH-1:0] result_q;
    logic [1:0] gnt;
    rr_arbiter2 u_arb (
        .clk(clk),
        .reset(reset),
        .req(req_valid),
        .advance(accept),
        .gnt(gnt)
    );
    // ready is gated by reset so no grant is visible while the block is held in reset
    assign req_ready = (state_q == IDLE && reset) ? gnt : 2'b00;
    assign accept = |(req_valid & req_ready);
    assign gid = gnt[1];
    assign sel_steps = gid ? req_steps1 : req_steps0;
    assign busy = state_q != IDLE;
    assign cnt_en = state_q == RUN;
    assign cnt_select = cnt_en && dir_q == DIR_DOWN;
    assign cnt_clear = state_q == CLEAR;
    assign done = (state_q == DONE) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign result = result_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            id_q <= 1'b0;
            dir_q <= DIR_UP;
            steps_q <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    id_q <= gid;
                    dir_q <= req_dir[gid];
                    steps_q <= sel_steps;
                    state_q <= req_clear[gid] ? CLEAR : (sel_steps != '0) ? RUN : DONE;
                end
                CLEAR: state_q <= (steps_q != '0) ? RUN : DONE;
                RUN: begin
                    steps_q <= steps_q - 1'b1;
                    if (steps_q == STEP_W'(1)) state_q <= DONE;
                end
                DONE: begin
                    result_q <= cnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
